// File: rtl/router_b.sv
// Operand-selection router in front of the Kalman datapath arithmetic unit.
// Picks and optionally inverts operands R and S, builds immediate I, and can register all outputs.
module router_b #(
    parameter int W       = 24,
    parameter bit REG_OUT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] RQ,
    input  logic [W-1:0] RD,
    input  logic [1:0]   sel_R,
    input  logic [1:0]   sel_S,
    input  logic         inv_R,
    input  logic         inv_S,
    input  logic [1:0]   sel_I,
    output logic [W-1:0] R,
    output logic [W-1:0] S,
    output logic [W-1:0] I,
    output logic         msb_R,
    output logic         msb_S
);

    logic [W-1:0] r_mux;
    logic [W-1:0] s_mux;
    logic [W-1:0] r_next;
    logic [W-1:0] s_next;
    logic [W-1:0] i_next;

    always_comb begin
        case (sel_R)
            2'b00:   r_mux = A;
            2'b01:   r_mux = RQ;
            2'b10:   r_mux = '0;
            default: r_mux = '1;
        endcase
        case (sel_S)
            2'b00:   s_mux = B;
            2'b01:   s_mux = RD;
            2'b10:   s_mux = '0;
            default: s_mux = '1;
        endcase
        // Inversion follows the mux so the constants flip as well.
        r_next = inv_R ? ~r_mux : r_mux;
        s_next = inv_S ? ~s_mux : s_mux;
        case (sel_I)
            2'b01:   i_next = {{(W-1){1'b0}}, 1'b1};
            2'b10:   i_next = '1;
            default: i_next = '0;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [W-1:0] r_reg;
            logic [W-1:0] s_reg;
            logic [W-1:0] i_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_reg <= '0;
                    s_reg <= '0;
                    i_reg <= '0;
                end else begin
                    r_reg <= r_next;
                    s_reg <= s_next;
                    i_reg <= i_next;
                end
            end

            assign R = r_reg;
            assign S = s_reg;
            assign I = i_reg;
        end else begin : g_comb
            // Clock and reset are intentionally ignored in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign R = r_next;
            assign S = s_next;
            assign I = i_next;
        end
    endgenerate

    // Sign bits come from the final outputs so they track the register stage too.
    assign msb_R = R[W-1];
    assign msb_S = S[W-1];

endmodule

// File: tb/tb_router_b.sv
// Bench for router_b: combinational and registered builds driven from shared inputs.
// Expected values come from an arithmetic model of the select/invert/immediate rules.
module tb_router_b;
    localparam int W = 24;
    localparam longint ONES = (64'd1 << W) - 1;
    localparam longint HALF = 64'd1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a, b, rq, rd;
    logic [1:0]   sel_r, sel_s, sel_i;
    logic         inv_r, inv_s;

    logic [W-1:0] r_c, s_c, i_c, r_q, s_q, i_q;
    logic         mr_c, ms_c, mr_q, ms_q;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sv_r, sv_s, sv_i;

    always #5 clk = ~clk;

    router_b #(.W(W), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .RQ(rq), .RD(rd),
        .sel_R(sel_r), .sel_S(sel_s), .inv_R(inv_r), .inv_S(inv_s), .sel_I(sel_i),
        .R(r_c), .S(s_c), .I(i_c), .msb_R(mr_c), .msb_S(ms_c)
    );

    router_b #(.W(W), .REG_OUT(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .RQ(rq), .RD(rd),
        .sel_R(sel_r), .sel_S(sel_s), .inv_R(inv_r), .inv_S(inv_s), .sel_I(sel_i),
        .R(r_q), .S(s_q), .I(i_q), .msb_R(mr_q), .msb_S(ms_q)
    );

    // Operand model: pick a value, then invert by subtracting from all-ones.
    function automatic logic [W-1:0] m_operand(input logic [1:0] sel, input logic [W-1:0] port,
                                               input logic [W-1:0] tmp, input logic inv);
        longint v;
        if (sel == 2'd0)      v = longint'(port);
        else if (sel == 2'd1) v = longint'(tmp);
        else if (sel == 2'd2) v = 0;
        else                  v = ONES;
        if (inv) v = ONES - v;
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] m_imm(input logic [1:0] sel);
        longint v;
        v = (sel == 2'd1) ? 1 : (sel == 2'd2) ? ONES : 0;
        return v[W-1:0];
    endfunction

    function automatic logic m_sign(input logic [W-1:0] v);
        return longint'(v) >= HALF;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        logic [W-1:0] er, es;
        er = m_operand(sel_r, a, rq, inv_r);
        es = m_operand(sel_s, b, rd, inv_s);
        chk({tag, ".R"}, r_c, er);
        chk({tag, ".S"}, s_c, es);
        chk({tag, ".I"}, i_c, m_imm(sel_i));
        chk({tag, ".msbR"}, W'(mr_c), W'(m_sign(er)));
        chk({tag, ".msbS"}, W'(ms_c), W'(m_sign(es)));
    endtask

    task automatic chk_reg(input string tag, input logic [W-1:0] er, input logic [W-1:0] es,
                           input logic [W-1:0] ei);
        chk({tag, ".R"}, r_q, er);
        chk({tag, ".S"}, s_q, es);
        chk({tag, ".I"}, i_q, ei);
        chk({tag, ".msbR"}, W'(mr_q), W'(m_sign(er)));
        chk({tag, ".msbS"}, W'(ms_q), W'(m_sign(es)));
        $display("reg %s R=%h S=%h I=%h", tag, r_q, s_q, i_q);
    endtask

    task automatic snap();
        sv_r = m_operand(sel_r, a, rq, inv_r);
        sv_s = m_operand(sel_s, b, rd, inv_s);
        sv_i = m_imm(sel_i);
    endtask

    logic [W-1:0] r_tab [4];
    logic [W-1:0] s_tab [4];
    logic [W-1:0] i_tab [4];

    initial begin
        r_tab = '{24'h123456, 24'h0FF00D, 24'h000000, 24'hFFFFFF};
        s_tab = '{24'hABCDEF, 24'hC0FFEE, 24'h000000, 24'hFFFFFF};
        i_tab = '{24'h000000, 24'h000001, 24'hFFFFFF, 24'h000000};

        a = 24'h123456; b = 24'hABCDEF; rq = 24'h0FF00D; rd = 24'hC0FFEE;
        sel_r = 2'd0; sel_s = 2'd0; sel_i = 2'd0; inv_r = 1'b0; inv_s = 1'b0;
        #2;
        chk_reg("reset", '0, '0, '0);
        chk_comb("comb_in_reset");

        // Source sweep, no inversion
        for (int k = 0; k < 4; k++) begin
            sel_r = 2'(k); sel_s = 2'(k); sel_i = 2'(k);
            #1;
            chk($sformatf("sweep%0d.R", k), r_c, r_tab[k]);
            chk($sformatf("sweep%0d.S", k), s_c, s_tab[k]);
            chk($sformatf("imm%0d.I", k), i_c, i_tab[k]);
            $display("sweep sel=%0d R=%h S=%h I=%h", k, r_c, s_c, i_c);
        end
        sel_r = 2'd0; sel_s = 2'd0; inv_r = 1'b0; inv_s = 1'b0; #1;
        chk("sign_S_B", W'(ms_c), W'(1'b1));
        chk("sign_R_A", W'(mr_c), W'(1'b0));

        // Inversion directed points
        inv_r = 1'b1; inv_s = 1'b1; sel_r = 2'd0; sel_s = 2'd1; #1;
        chk("inv.R_A", r_c, 24'hEDCBA9);
        chk("inv.S_RD", s_c, 24'h3F0011);
        $display("inv R=%h S=%h", r_c, s_c);
        sel_r = 2'd2; sel_s = 2'd3; #1;
        chk("inv.R_zero", r_c, 24'hFFFFFF);
        chk("inv.S_ones", s_c, 24'h000000);
        $display("inv R=%h S=%h", r_c, s_c);

        // Exhaustive select cross with random operand data
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++)
                for (int ir = 0; ir < 2; ir++)
                    for (int is = 0; is < 2; is++)
                        for (int im = 0; im < 3; im++) begin
                            a = W'($urandom); b = W'($urandom);
                            rq = W'($urandom); rd = W'($urandom);
                            sel_r = 2'(r); sel_s = 2'(s); sel_i = 2'(im);
                            inv_r = 1'(ir); inv_s = 1'(is);
                            #1;
                            chk_comb($sformatf("x%0d%0d%0d%0d%0d", r, s, ir, is, im));
                            $display("cross r=%0d s=%0d ir=%0d is=%0d i=%0d R=%h S=%h I=%h",
                                     r, s, ir, is, im, r_c, s_c, i_c);
                        end
        sel_i = 2'd3; #1;
        chk_comb("imm_reserved");

        // Registered build: latency, async reset, resume
        @(negedge clk);
        rst_n = 1'b1;
        a = 24'h123456; b = 24'hABCDEF; rq = 24'h0FF00D; rd = 24'hC0FFEE;
        sel_r = 2'd0; sel_s = 2'd0; sel_i = 2'd1; inv_r = 1'b0; inv_s = 1'b0;
        #1;
        chk_reg("hold_before_edge", '0, '0, '0);
        snap();
        @(posedge clk); #1;
        chk_reg("edge1", sv_r, sv_s, sv_i);

        @(negedge clk);
        a = W'($urandom); b = W'($urandom); rq = W'($urandom); rd = W'($urandom);
        sel_r = 2'd1; sel_s = 2'd1; sel_i = 2'd2; inv_r = 1'b1; inv_s = 1'b0;
        #1;
        chk_reg("latency_hold", sv_r, sv_s, sv_i);
        snap();
        @(posedge clk); #1;
        chk_reg("edge2", sv_r, sv_s, sv_i);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reg("async_clear", '0, '0, '0);
        sel_r = 2'd3; sel_s = 2'd3; sel_i = 2'd1; inv_r = 1'b0; inv_s = 1'b0;
        @(posedge clk); #1;
        chk_reg("reset_hold", '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reg("after_release", '0, '0, '0);
        snap();
        @(posedge clk); #1;
        chk_reg("resume", sv_r, sv_s, sv_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
